game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level pinball game sequencer. It drives the shared 3-bit game `state` bus (RESET/WAIT/START/GET/OVER) and the `flash_clk` tick consumed by the group-select logic. It also debounces the player buttons and keeps ball count and score. It consumes `selected_group` back from group select and playfield event pulses.

## Interface
Parameters:
- `FLASH_DIV`, 12_500_000: clock cycles between `flash_clk` pulses (must be ≥2).
- `DB_CYCLES`, 16: consecutive stable synchronized samples required to change a debounced button level (≥1).
- `BALLS`, 3: balls per game (1..3).

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `btn_start`  in  1  raw start button, asynchronous.
- `btn_down`  in  1  raw launch button, asynchronous.
- `ball_lost`  in  1  one-cycle pulse from playfield: ball drained.
- `target_hit`  in  1  one-cycle pulse from playfield: target struck.
- `selected_group`  in  3  group chosen by group select.
- `state`  out  3  game state: 0 RESET, 1 WAIT, 2 START, 3 GET, 4 OVER.
- `flash_clk`  out  1  one-cycle tick, active only in WAIT.
- `btn_down_pulse`  out  1  debounced one-cycle rising-edge pulse of `btn_down`.
- `balls_left`  out  2  balls remaining.
- `score`  out  8  accumulated score, saturating.

## Operation
- Button path, per button: 2-flop synchronizer, then debouncer, then edge detector.
  - The debounced level flips after `DB_CYCLES` consecutive synchronized samples differ from it.
  - The pulse is one cycle on the 0→1 flip of the debounced level.
  - `btn_start_pulse` is internal.
- FSM, one transition per cycle:
  - RESET: load `balls_left`=`BALLS` and `score`=0, then go to WAIT next cycle.
  - WAIT: flash divider runs. `btn_down_pulse` → START.
  - START:
    - `ball_lost` → ball-loss rule.
    - Otherwise `target_hit` → GET.
    - `ball_lost` has priority when both are asserted in the same cycle; the hit is dropped.
  - GET, lasts exactly 1 cycle:
    - Always adds `selected_group`+1 to `score`, saturating at 255.
    - `ball_lost` in this cycle → ball-loss rule (score still added).
    - Otherwise → START.
  - Ball-loss rule:
    - `balls_left`==1 → OVER with `balls_left`=0.
    - Otherwise decrement `balls_left` and go to WAIT.
  - OVER: `btn_start_pulse` → RESET. All other inputs are ignored.
  - Unused encodings 5–7 → RESET next cycle.
- Inputs ignored outside their states: `target_hit` outside START, `btn_down_pulse` outside WAIT, `btn_start_pulse` outside OVER.
- Flash divider:
  - Counter cleared whenever `state`≠WAIT.
  - In WAIT it counts 0..`FLASH_DIV`-1. At `FLASH_DIV`-1, `flash_clk`=1 for that cycle and the counter wraps to 0.
- Score arithmetic: 9-bit sum of `score` + {`selected_group`}+1. If the sum is >255, `score` becomes 255.

## Timing
- Reset values:
  - `state`=0.
  - `flash_clk`=0 and `btn_down_pulse`=0.
  - `balls_left`=`BALLS`, `score`=0.
  - All synchronizer, debouncer, edge and divider registers = 0.
- Asserting `reset` mid-game forces all of the above immediately. The first state after release is RESET for 1 cycle, then WAIT.
- All outputs are registered. `state` changes on the edge following the qualifying input.
- Button latency: with a clean raw rising edge first sampled at edge k, `btn_down_pulse` is high in the cycle after edge k+`DB_CYCLES`+2. A raw glitch shorter than `DB_CYCLES` cycles produces no pulse.
- First `flash_clk` comes `FLASH_DIV` cycles after the first WAIT cycle. Subsequent pulses follow every `FLASH_DIV` cycles.
- GET is visible on `state` for exactly one cycle. `score` updates on the edge that leaves GET.
- A button held continuously produces one pulse only. Release plus re-press is required for another.

## Test plan
Run with `FLASH_DIV`=4, `DB_CYCLES`=2, `BALLS`=3.
- Release `reset` → `state`=0 for 1 cycle, then 1. `balls_left`=3, `score`=0. `flash_clk` pulses every 4th cycle while in WAIT.
- In WAIT, hold `btn_down` high 10 cycles → exactly one `btn_down_pulse`, 5 cycles after first sample. `state`→2 and the flash counter clears. A 1-cycle glitch on `btn_down` → no pulse.
- In START with `selected_group`=5, pulse `target_hit` → `state`=3 for 1 cycle, then 2. `score`=6. Repeat 43 times → `score` saturates at 255.
- In START, assert `target_hit` and `ball_lost` together → `state`=1, `balls_left`=2, `score` unchanged.
- Lose 3 balls → `state`=4, `balls_left`=0. `btn_down` is ignored. A `btn_start` press → RESET then WAIT, `balls_left`=3, `score`=0.
- Assert `reset` low while in GET → all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/game_ctrl.sv
// Pinball game sequencer: debounced buttons, game-state FSM, WAIT-state flash tick,
// ball count and saturating score.
module game_ctrl #(
  parameter int FLASH_DIV = 12_500_000,
  parameter int DB_CYCLES = 16,
  parameter int BALLS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_down,
  input  logic       ball_lost,
  input  logic       target_hit,
  input  logic [2:0] selected_group,
  output logic [2:0] state,
  output logic       flash_clk,
  output logic       btn_down_pulse,
  output logic [1:0] balls_left,
  output logic [7:0] score
);

  localparam int              DIV_W   = $clog2(FLASH_DIV);
  localparam int              DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FLASH_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);
  localparam logic [1:0]       BALLS_V = 2'(BALLS);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_GET   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // Bit 0 is the launch button, bit 1 the start button.
  logic [1:0] w_raw;
  logic [1:0] w_pulse;
  assign w_raw = {btn_start, btn_down};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_level;
      logic            r_level_d;
      logic            r_pulse;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_s1      <= 1'b0;
          r_s2      <= 1'b0;
          r_level   <= 1'b0;
          r_level_d <= 1'b0;
          r_pulse   <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          // Count consecutive samples that disagree with the debounced level.
          if (r_s2 != r_level) begin
            if (r_cnt == DB_MAX) begin
              r_level <= r_s2;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
          r_level_d <= r_level;
          r_pulse   <= r_level & ~r_level_d;
        end
      end

      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_balls;
  logic [1:0]       w_balls_next;
  logic [7:0]       r_score;
  logic [7:0]       w_score_next;
  logic [8:0]       w_sum;
  logic             w_lose;
  logic [DIV_W-1:0] r_div;
  logic             r_flash;

  assign w_sum = {1'b0, r_score} + {6'd0, selected_group} + 9'd1;

  always_comb begin
    w_state_next = r_state;
    w_balls_next = r_balls;
    w_score_next = r_score;
    w_lose       = 1'b0;
    case (r_state)
      S_RESET: begin
        w_state_next = S_WAIT;
        w_balls_next = BALLS_V;
        w_score_next = 8'd0;
      end
      S_WAIT: begin
        if (w_pulse[0]) w_state_next = S_START;
      end
      S_START: begin
        if (ball_lost)       w_lose       = 1'b1;
        else if (target_hit) w_state_next = S_GET;
      end
      S_GET: begin
        w_score_next = (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
        if (ball_lost) w_lose       = 1'b1;
        else           w_state_next = S_START;
      end
      S_OVER: begin
        if (w_pulse[1]) w_state_next = S_RESET;
      end
      default: w_state_next = S_RESET;
    endcase
    if (w_lose) begin
      if (r_balls == 2'd1) begin
        w_state_next = S_OVER;
        w_balls_next = 2'd0;
      end else begin
        w_state_next = S_WAIT;
        w_balls_next = r_balls - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
      r_balls <= BALLS_V;
      r_score <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_balls <= w_balls_next;
      r_score <= w_score_next;
    end
  end

  // Counter holds zero outside WAIT, so the first WAIT cycle always starts a fresh period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div   <= '0;
      r_flash <= 1'b0;
    end else begin
      if (r_state == S_WAIT && w_state_next == S_WAIT && r_div != DIV_MAX)
        r_div <= r_div + 1'b1;
      else
        r_div <= '0;
      r_flash <= (r_state == S_WAIT) && (w_state_next == S_WAIT) && (r_div == DIV_MAX);
    end
  end

  assign state          = r_state;
  assign flash_clk      = r_flash;
  assign btn_down_pulse = w_pulse[0];
  assign balls_left     = r_balls;
  assign score          = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized scoreboard bench for game_ctrl: a rule-level game model predicts every
// cycle's outputs into a queue, and a monitor pops and compares after each clock edge.
module tb_game_ctrl;
  localparam int FLASH_DIV = 4;
  localparam int DB_CYCLES = 2;
  localparam int BALLS     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_down = 1'b0;
  logic       ball_lost = 1'b0;
  logic       target_hit = 1'b0;
  logic [2:0] selected_group = 3'd0;
  logic [2:0] state;
  logic       flash_clk;
  logic       btn_down_pulse;
  logic [1:0] balls_left;
  logic [7:0] score;

  always #5 clk = ~clk;

  game_ctrl #(.FLASH_DIV(FLASH_DIV), .DB_CYCLES(DB_CYCLES), .BALLS(BALLS)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_down(btn_down),
    .ball_lost(ball_lost), .target_hit(target_hit), .selected_group(selected_group),
    .state(state), .flash_clk(flash_clk), .btn_down_pulse(btn_down_pulse),
    .balls_left(balls_left), .score(score)
  );

  typedef struct {
    int st;
    int fl;
    int pu;
    int balls;
    int score;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input int want);
    checks++;
    if (act !== 8'(want)) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, want);
    end
  endtask

  // ---------------- reference model (game rules) ----------------
  int m_state, m_balls, m_score, m_wait_n, m_flash;
  bit m_lvl[2];
  bit m_rose[2];
  bit m_pulse[2];
  bit hist_d[$];
  bit hist_s[$];

  function automatic bit hist_get(int b, int idx);
    if (idx < 0) return 1'b0;
    if (b == 0) return hist_d[idx];
    return hist_s[idx];
  endfunction

  function automatic void model_reset();
    m_state = 0; m_balls = BALLS; m_score = 0; m_wait_n = 0; m_flash = 0;
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 1'b0; m_rose[k] = 1'b0; m_pulse[k] = 1'b0;
    end
    hist_d.delete();
    hist_s.delete();
  endfunction

  function automatic void model_step();
    int ns;
    bit lose;
    bit flip;
    int sum;
    ns = m_state;
    lose = 1'b0;
    case (m_state)
      0: begin ns = 1; m_balls = BALLS; m_score = 0; end
      1: if (m_pulse[0]) ns = 2;
      2: begin
        if (ball_lost) lose = 1'b1;
        else if (target_hit) ns = 3;
      end
      3: begin
        sum = m_score + int'(selected_group) + 1;
        m_score = (sum > 255) ? 255 : sum;
        if (ball_lost) lose = 1'b1;
        else ns = 2;
      end
      4: if (m_pulse[1]) ns = 0;
      default: ns = 0;
    endcase
    if (lose) begin
      if (m_balls == 1) begin ns = 4; m_balls = 0; end
      else begin m_balls = m_balls - 1; ns = 1; end
    end
    // Flash fires on every FLASH_DIV-th cycle of an unbroken WAIT stretch.
    if (m_state == 1 && ns == 1) begin
      m_wait_n++;
      m_flash = (m_wait_n % FLASH_DIV == 0) ? 1 : 0;
    end else begin
      m_wait_n = 0;
      m_flash = 0;
    end
    m_state = ns;
    // Debounced level flips once the last DB_CYCLES synchronized samples (raw delayed 2) all differ.
    hist_d.push_back(btn_down);
    hist_s.push_back(btn_start);
    for (int k = 0; k < 2; k++) begin
      flip = 1'b1;
      for (int i = 0; i < DB_CYCLES; i++)
        if (hist_get(k, hist_d.size() - 3 - i) == m_lvl[k]) flip = 1'b0;
      m_pulse[k] = m_rose[k];
      if (flip) begin
        m_lvl[k] = !m_lvl[k];
        m_rose[k] = m_lvl[k];
      end else begin
        m_rose[k] = 1'b0;
      end
    end
  endfunction

  always @(negedge reset) begin
    model_reset();
    exp_q.delete();
  end

  always @(posedge clk) begin
    exp_t e;
    if (!reset) model_reset();
    else model_step();
    e = '{m_state, m_flash, m_pulse[0], m_balls, m_score};
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  int prev_st = -1;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("state", {5'd0, state}, e.st);
      chk("flash_clk", {7'd0, flash_clk}, e.fl);
      chk("btn_down_pulse", {7'd0, btn_down_pulse}, e.pu);
      chk("balls_left", {6'd0, balls_left}, e.balls);
      chk("score", score, e.score);
      if (e.st != prev_st)
        $display("tx t=%0t state=%0d balls=%0d score=%0d", $time, e.st, e.balls, e.score);
      prev_st = e.st;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_down(input int n);
    btn_down = 1'b1;
    wait_cycles(n);
    btn_down = 1'b0;
  endtask

  task automatic press_start(input int n);
    btn_start = 1'b1;
    wait_cycles(n);
    btn_start = 1'b0;
  endtask

  task automatic lose_ball();
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    int hd;
    int hs;
    hd = 0;
    hs = 0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(14);

    // One-cycle glitch must not produce a pulse.
    btn_down = 1'b1;
    @(negedge clk);
    btn_down = 1'b0;
    wait_cycles(8);

    press_down(10);
    wait_cycles(6);

    for (int i = 0; i < 43; i++) begin
      selected_group = 3'd5;
      target_hit = 1'b1;
      @(negedge clk);
      target_hit = 1'b0;
      @(negedge clk);
    end

    target_hit = 1'b1;
    ball_lost = 1'b1;
    @(negedge clk);
    target_hit = 1'b0;
    ball_lost = 1'b0;
    wait_cycles(2);

    press_down(6);
    wait_cycles(6);
    lose_ball();
    press_down(6);
    wait_cycles(6);
    lose_ball();
    press_down(6);
    wait_cycles(6);
    press_start(6);
    wait_cycles(8);

    for (int c = 0; c < 400; c++) begin
      if (hd == 0) begin btn_down = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 6); end
      if (hs == 0) begin btn_start = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 6); end
      hd--;
      hs--;
      target_hit = ($urandom_range(0, 2) == 0);
      ball_lost = ($urandom_range(0, 9) == 0);
      selected_group = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    btn_down = 1'b0;
    btn_start = 1'b0;
    target_hit = 1'b0;
    ball_lost = 1'b0;

    reset = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);

    // Steer into GET, then drop reset between clock edges.
    press_down(6);
    for (int i = 0; i < 12 && state != 3'd2; i++) @(negedge clk);
    chk("reach_start", {5'd0, state}, 2);
    selected_group = 3'($urandom_range(0, 7));
    target_hit = 1'b1;
    @(posedge clk);
    #2;
    chk("reach_get", {5'd0, state}, 3);
    reset = 1'b0;
    #1;
    chk("async_state", {5'd0, state}, 0);
    chk("async_flash", {7'd0, flash_clk}, 0);
    chk("async_pulse", {7'd0, btn_down_pulse}, 0);
    chk("async_balls", {6'd0, balls_left}, BALLS);
    chk("async_score", score, 0);
    target_hit = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
